// File: rtl/scorer_pkg.sv
// Shared types and the seven-segment table for the match scorer.
package scorer_pkg;

  typedef enum logic [1:0] {PLAY, HOLD, DONE} scorer_state_t;

  // Active-low, bit order gfedcba, indexed by digit value.
  localparam logic [6:0] SEG_DIGIT [0:7] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000
  };

endpackage

// File: rtl/seg7_digit.sv
// Decodes a 3-bit score into an active-low seven-segment pattern.
module seg7_digit
  import scorer_pkg::*;
(
  input  logic [2:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DIGIT[value];
  end

endmodule

// File: rtl/match_scorer.sv
// Match-level scorekeeper: edge-detects round wins, keeps saturating scores,
// holds the light controller in reset between rounds and latches match end.
module match_scorer
  import scorer_pkg::*;
#(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       win1,
  input  logic       win2,
  output logic       round_reset,
  output logic       match_over,
  output logic [1:0] leader,
  output logic [6:0] hex_p1,
  output logic [6:0] hex_p2
);

  localparam logic [2:0] WinScore  = 3'(WIN_SCORE);
  localparam logic [7:0] HoldLoad  = 8'(HOLD_CYCLES - 1);

  scorer_state_t state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [2:0]    score1_q, score1_d;
  logic [2:0]    score2_q, score2_d;
  logic          win1_q, win2_q;
  logic          edge1, edge2;

  assign edge1 = win1 & ~win1_q;
  assign edge2 = win2 & ~win2_q;

  // Edge history resets high so a win held across reset release is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PLAY;
      cnt_q    <= '0;
      score1_q <= '0;
      score2_q <= '0;
      win1_q   <= 1'b1;
      win2_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      win1_q   <= win1;
      win2_q   <= win2;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    score1_d = score1_q;
    score2_d = score2_q;
    unique case (state_q)
      PLAY: begin
        if (edge1 && edge2) begin
          state_d = HOLD;
          cnt_d   = HoldLoad;
        end else if (edge1) begin
          if (score1_q < WinScore) score1_d = score1_q + 3'd1;
          state_d = (score1_d == WinScore) ? DONE : HOLD;
          cnt_d   = HoldLoad;
        end else if (edge2) begin
          if (score2_q < WinScore) score2_d = score2_q + 3'd1;
          state_d = (score2_d == WinScore) ? DONE : HOLD;
          cnt_d   = HoldLoad;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = PLAY;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: state_d = DONE;
      default: state_d = PLAY;
    endcase
  end

  always_comb begin
    round_reset = (state_q != PLAY);
    match_over  = (state_q == DONE);
    if (score1_q > score2_q) begin
      leader = 2'b10;
    end else if (score2_q > score1_q) begin
      leader = 2'b01;
    end else begin
      leader = 2'b00;
    end
  end

  seg7_digit u_seg_p1 (
    .value (score1_q),
    .seg   (hex_p1)
  );

  seg7_digit u_seg_p2 (
    .value (score2_q),
    .seg   (hex_p2)
  );

endmodule

// File: tb/tb_match_scorer.sv
// Directed bench for match_scorer with hand-computed expectations.
module tb_match_scorer;

  logic       clk;
  logic       reset;
  logic       win1;
  logic       win2;
  logic       round_reset;
  logic       match_over;
  logic [1:0] leader;
  logic [6:0] hex_p1;
  logic [6:0] hex_p2;

  int unsigned n_checks;
  int unsigned n_errors;

  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D6 = 7'b0000010;
  localparam logic [6:0] D7 = 7'b1111000;

  match_scorer #(
    .WIN_SCORE   (7),
    .HOLD_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .win1        (win1),
    .win2        (win2),
    .round_reset (round_reset),
    .match_over  (match_over),
    .leader      (leader),
    .hex_p1      (hex_p1),
    .hex_p2      (hex_p2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".hex_p1"}, 32'(hex_p1), 32'(D0));
    check({tag, ".hex_p2"}, 32'(hex_p2), 32'(D0));
    check({tag, ".round_reset"}, 32'(round_reset), 32'd0);
    check({tag, ".match_over"}, 32'(match_over), 32'd0);
    check({tag, ".leader"}, 32'(leader), 32'd0);
  endtask

  task automatic pulse2();
    win2 = 1'b1;
    tick();
    win2 = 1'b0;
    tick(5);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    win1  = 1'b0;
    win2  = 1'b0;
    #2;
    tick(2);
    check_reset_vals("reset");
    reset = 1'b0;
    tick();

    // Single score, win1 held high for 10 cycles
    win1 = 1'b1;
    tick();
    check("single.hex_p1", 32'(hex_p1), 32'(D1));
    check("single.leader", 32'(leader), 32'b10);
    check("single.rr_k", 32'(round_reset), 32'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("single.rr_k%0d", i), 32'(round_reset), 32'd1);
    end
    tick();
    check("single.rr_low", 32'(round_reset), 32'd0);
    tick(5);
    check("single.held_no_inc", 32'(hex_p1), 32'(D1));
    check("single.held_rr", 32'(round_reset), 32'd0);
    win1 = 1'b0;
    tick();

    // Simultaneous wins void the round
    win1 = 1'b1;
    win2 = 1'b1;
    tick();
    check("both.rr", 32'(round_reset), 32'd1);
    check("both.hex_p1", 32'(hex_p1), 32'(D1));
    check("both.hex_p2", 32'(hex_p2), 32'(D0));
    tick(3);
    check("both.rr_last", 32'(round_reset), 32'd1);
    tick();
    check("both.rr_low", 32'(round_reset), 32'd0);
    win1 = 1'b0;
    win2 = 1'b0;
    tick();

    // Player 2 scores to match end
    pulse2();
    check("p2.tie_leader", 32'(leader), 32'b00);
    pulse2();
    pulse2();
    check("p2.hex3", 32'(hex_p2), 32'(D3));
    check("p2.lead3", 32'(leader), 32'b01);
    pulse2();
    pulse2();
    pulse2();
    check("p2.hex6", 32'(hex_p2), 32'(D6));
    check("p2.mo6", 32'(match_over), 32'd0);
    win2 = 1'b1;
    tick();
    check("p2.hex7", 32'(hex_p2), 32'(D7));
    check("p2.match_over", 32'(match_over), 32'd1);
    win2 = 1'b0;
    tick(10);
    check("p2.rr_stuck", 32'(round_reset), 32'd1);
    pulse2();
    check("p2.saturate", 32'(hex_p2), 32'(D7));
    check("p2.mo_stuck", 32'(match_over), 32'd1);

    // Reset while DONE
    reset = 1'b1;
    tick();
    check_reset_vals("rst_done");
    reset = 1'b0;
    tick();

    // Reset two cycles into HOLD
    win1 = 1'b1;
    tick();
    check("hold.hex_p1", 32'(hex_p1), 32'(D1));
    win1 = 1'b0;
    tick(2);
    check("hold.rr", 32'(round_reset), 32'd1);
    reset = 1'b1;
    tick();
    check_reset_vals("rst_hold");
    reset = 1'b0;
    tick();

    // win1 held high across reset release
    win1  = 1'b1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3);
    check("across.hex_p1", 32'(hex_p1), 32'(D0));
    check("across.rr", 32'(round_reset), 32'd0);
    win1 = 1'b0;
    tick();
    win1 = 1'b1;
    tick();
    check("across.rise_hex", 32'(hex_p1), 32'(D1));
    check("across.rise_rr", 32'(round_reset), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/match_scorer.md
# match_scorer

Match-level scorekeeper downstream of the tug-of-war light controller. Consumes the per-round `win1`/`win2` flags, keeps a saturating score per player, and drives the two score HEX digits. Asserts a timed `round_reset` that clears the light controller between rounds, and latches end-of-match once either player reaches `WIN_SCORE`.

## Interface
Parameters:
- `WIN_SCORE`, default 7: points needed to win the match; legal range 1–7.
- `HOLD_CYCLES`, default 4: cycles `round_reset` stays high after a scored round; legal range 1–255.

Ports:
- `clk`  in  1  system clock; the divided game clock in the top level.
- `reset`  in  1  synchronous, active-high reset.
- `win1`  in  1  player 1 (left, `HEX5`) won the round; level, may stay high until the light controller is reset.
- `win2`  in  1  player 2 (right, `HEX0`) won the round; level, same rules as `win1`.
- `round_reset`  out  1  active-high clear for the light controller, ORed with `reset` in the top level.
- `match_over`  out  1  high once a player reaches `WIN_SCORE`.
- `leader`  out  2  `2'b10` player 1 ahead, `2'b01` player 2 ahead, `2'b00` tied.
- `hex_p1`  out  7  active-low seven-segment digit for the player 1 score.
- `hex_p2`  out  7  active-low seven-segment digit for the player 2 score.

## Operation
- **Edge detect.**
  - `win1_q`/`win2_q` hold last cycle's inputs.
  - An accepted event is a rising edge (`winX & ~winX_q`) sampled in PLAY only.
  - Edges in HOLD and DONE are ignored, but the `_q` registers keep tracking.
- **Scores.**
  - `score1`, `score2` are 3-bit unsigned.
  - An increment never exceeds `WIN_SCORE`; this is a saturating update, never a wrap.
- **States: PLAY, HOLD, DONE.**
  - PLAY, single edge on `winX`:
    - `scoreX += 1`.
    - If the new `scoreX == WIN_SCORE`, go to DONE; otherwise go to HOLD.
    - The hold counter loads `HOLD_CYCLES-1`.
  - PLAY, both edges in the same cycle: void round, no score change, go to HOLD.
  - HOLD: the counter decrements each cycle; PLAY is re-entered on the cycle after the counter reads 0.
  - DONE: absorbing; only `reset` leaves it.
- **Outputs.**
  - `round_reset` is 1 in HOLD and DONE, 0 in PLAY.
  - `match_over` is 1 in DONE only.
  - `leader` compares the registered scores.
- **Seven-segment encoding** (active-low, bit order gfedcba):
  - 0 = `1000000`, 1 = `1111001`, 2 = `0100100`, 3 = `0110000`
  - 4 = `0011001`, 5 = `0010010`, 6 = `0000010`, 7 = `1111000`
- **Reset values** (every output):
  - state PLAY; scores 0; counter 0.
  - `round_reset` 0, `match_over` 0, `leader` `2'b00`.
  - `hex_p1` = `hex_p2` = `1000000`.
  - `win1_q` = `win2_q` = 1, so a win held high across reset release is not counted.
- **Reset mid-operation:** `reset` overrides every state, including HOLD part-way through its count and DONE.

## Timing
- All state, scores and counter are registered.
- `hex_*` and `leader` are decoded combinationally from the registered scores, with no further registering.
- **Score latency:** `win1` rises before edge k, so `score1`, `hex_p1`, `leader` and `round_reset` all change after edge k. One cycle from input to output.
- **Hold length:** `round_reset` is high for exactly `HOLD_CYCLES` cycles (edge k through edge k+`HOLD_CYCLES`), then low after edge k+`HOLD_CYCLES`.
- **Earliest next score:** a new rising edge is counted at edge k+`HOLD_CYCLES`+1 at the soonest.
- A `win` level held high through HOLD produces no edge on return to PLAY; it must fall and rise again.
- **Reset:** `reset` high at edge r means every output holds its reset value after edge r.

## Structure
- Package `scorer_pkg`:
  - `typedef enum logic [1:0] {PLAY, HOLD, DONE} scorer_state_t`
  - `localparam logic [6:0] SEG_DIGIT [0:7]`, the encoding table above.
- Sub-module `seg7_digit`: 3-bit value in, 7-bit active-low pattern out. Instantiated twice.
- Top-level hookup in `DE1_SoC`:
  - `win1`/`win2` come from `light_control`.
  - `hex_p1`/`hex_p2` drive `HEX5`/`HEX0`, replacing the two `counter` instances.
  - `round_reset | reset` goes to the `light_control` reset.

## Test plan
- **Reset:** `reset`=1 for 2 cycles → `hex_p1` = `hex_p2` = `1000000`, `round_reset`=0, `match_over`=0, `leader`=00.
- **Single score:** `win1` rises and is held high 10 cycles, `HOLD_CYCLES`=4 → `score1`=1, `hex_p1`=`1111001`, `leader`=10. `round_reset` high exactly 4 cycles. No second increment while held.
- **Simultaneous wins:** `win1` and `win2` rise on the same cycle → scores unchanged, `round_reset` high 4 cycles, back to PLAY.
- **Match end:** 7 separated `win2` pulses → `hex_p2`=`1111000`, `match_over`=1, `round_reset` stuck 1. An 8th pulse leaves `score2`=7.
- **Reset in HOLD and DONE:** `reset` asserted 2 cycles into HOLD, and again in DONE → all outputs return to reset values after that edge.
- **Held across reset:** `win1` held high across reset release → no score; score counts only after `win1` falls and rises again.
